// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register offsets and status bit positions.
package mmio_pkg;

    typedef logic [7:0] mmio_off_t;

    // The window spans 2^WIN_BITS bytes starting at ADDR_BASE.
    localparam int WIN_BITS = 8;

    localparam mmio_off_t OFF_STATUS = 8'h00;
    localparam mmio_off_t OFF_RX     = 8'h04;
    localparam mmio_off_t OFF_TX     = 8'h08;
    localparam mmio_off_t OFF_CYC    = 8'h10;
    localparam mmio_off_t OFF_INST   = 8'h14;
    localparam mmio_off_t OFF_CRST   = 8'h18;

    localparam int ST_TX_READY = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_TX_OVF   = 2;

endpackage

// File: rtl/mmio_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Single-cycle MMIO responder for UART and performance counters.
// Define MMIO_TX_FIFO_EN to replace the one-byte TX holding register with a TX_FIFO_DEPTH FIFO.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE     = 32'h8000_0000,
    parameter int          COUNTER_WIDTH = 32,
    parameter int          TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    input  logic        inst_retire,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

`ifdef MMIO_TX_FIFO_EN
    localparam int TX_DEPTH = TX_FIFO_DEPTH;
`else
    localparam int TX_DEPTH = 1;
`endif

    if (TX_FIFO_DEPTH < 2 || (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("TX_FIFO_DEPTH must be a power of two and at least 2");
    end

    logic                     hit, is_ld, is_st;
    mmio_off_t                off;
    logic                     tx_push, tx_pop, tx_full, tx_empty;
    logic                     status_wr, cnt_clr, rx_pop, rx_cap;
    logic                     tx_ovf_q, tx_ovf_d;
    logic                     rx_full_q, rx_full_d;
    logic [7:0]               rx_data_q, rx_data_d;
    logic [COUNTER_WIDTH-1:0] cyc_q, cyc_d, inst_q, inst_d;
    logic                     resp_valid_q;
    logic [31:0]              resp_rdata_q, rdata_d;
    logic                     unused_bits;

    assign unused_bits = ^{req_wdata[31:8], req_be[3:1], req_addr[1:0]};

    assign hit   = (req_addr[31:WIN_BITS] == ADDR_BASE[31:WIN_BITS]);
    assign off   = {req_addr[WIN_BITS-1:2], 2'b00};
    assign is_ld = req_valid && !req_we;
    assign is_st = req_valid && req_we && hit;

    assign status_wr = is_st && (off == OFF_STATUS);
    assign cnt_clr   = is_st && (off == OFF_CRST);
    assign tx_push   = is_st && (off == OFF_TX) && req_be[0];
    assign tx_pop    = uart_tx_valid && uart_tx_ready;
    assign rx_pop    = is_ld && hit && (off == OFF_RX) && rx_full_q;
    assign rx_cap    = uart_rx_valid && uart_rx_ready;

    mmio_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_push),
        .data_i  (req_wdata[7:0]),
        .pop_i   (tx_pop),
        .data_o  (uart_tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign uart_tx_valid = !tx_empty;
    assign uart_rx_ready = !rx_full_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;

    always_comb begin
        tx_ovf_d = tx_ovf_q;
        if (status_wr) tx_ovf_d = 1'b0;
        else if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;

        rx_full_d = rx_full_q;
        rx_data_d = rx_data_q;
        if (rx_cap) begin
            rx_full_d = 1'b1;
            rx_data_d = uart_rx_data;
        end else if (rx_pop) begin
            rx_full_d = 1'b0;
        end

        // Clear wins over the same-cycle increment.
        cyc_d  = cnt_clr ? '0 : cyc_q + COUNTER_WIDTH'(1);
        inst_d = cnt_clr ? '0 : inst_q + (inst_retire ? COUNTER_WIDTH'(1) : '0);
    end

    // Read data is built from pre-edge state.
    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (off)
                OFF_STATUS: begin
                    rdata_d[ST_TX_READY] = !tx_full;
                    rdata_d[ST_RX_VALID] = rx_full_q;
                    rdata_d[ST_TX_OVF]   = tx_ovf_q;
                end
                OFF_RX:   rdata_d = rx_full_q ? {24'b0, rx_data_q} : '0;
                OFF_CYC:  rdata_d = 32'(cyc_q);
                OFF_INST: rdata_d = 32'(inst_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf_q     <= 1'b0;
            rx_full_q    <= 1'b0;
            rx_data_q    <= '0;
            cyc_q        <= '0;
            inst_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            tx_ovf_q     <= tx_ovf_d;
            rx_full_q    <= rx_full_d;
            rx_data_q    <= rx_data_d;
            cyc_q        <= cyc_d;
            inst_q       <= inst_d;
            resp_valid_q <= is_ld;
            if (is_ld) resp_rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder; TX tests follow the MMIO_TX_FIFO_EN build.
module tb_mmio_responder;

    localparam logic [31:0] B = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        inst_retire;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid, uart_rx_ready;

    int total = 0;
    int bad   = 0;

    mmio_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_be        (req_be),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .inst_retire   (inst_retire),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic [31:0] a, output logic [31:0] d, output logic v);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        d = resp_rdata; v = resp_valid;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = wd; req_be = be;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        rst_n = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
        inst_retire = 0; uart_tx_ready = 0; uart_rx_data = 0; uart_rx_valid = 0;
        #3 rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
        total++; if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h0) begin bad++;
            $display("FAIL rst_tx got valid=%b data=%h exp 0/00", uart_tx_valid, uart_tx_data); end
        total++; if (uart_rx_ready !== 1'b1) begin bad++; $display("FAIL rst_rx_ready got=%b exp=1", uart_rx_ready); end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        do_load(B + 32'h10, d, v);
        total++; if (v !== 1'b1 || d !== 32'd10) begin bad++;
            $display("FAIL cycle_count_read got v=%b d=%0d exp v=1 d=10", v, d); end
        @(posedge clk); #1;
        total++; if (resp_valid !== 1'b0 || resp_rdata !== 32'd10) begin bad++;
            $display("FAIL resp_idle_hold got v=%b d=%h exp v=0 d=0000000a", resp_valid, resp_rdata); end
        do_load(B, d, v);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL status_idle got=%h exp=00000001", d); end
    endtask

    task automatic test_tx_single();
        logic [31:0] d; logic v;
        uart_tx_ready = 1'b0;
        do_store(B + 32'h08, 32'h41, 4'b0001);
        total++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin bad++;
            $display("FAIL tx_load got valid=%b data=%h exp 1/41", uart_tx_valid, uart_tx_data); end
        do_store(B + 32'h08, 32'h42, 4'b0001);
        total++; if (uart_tx_data !== 8'h41) begin bad++; $display("FAIL tx_drop got=%h exp=41", uart_tx_data); end
        do_load(B, d, v);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL tx_overflow_status got=%h exp=00000004", d); end
        uart_tx_ready = 1'b1;
        @(posedge clk); #1;
        uart_tx_ready = 1'b0;
        total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL tx_handshake got valid=%b exp=0", uart_tx_valid); end
        do_store(B, 32'h0, 4'hF);
        do_load(B, d, v);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL tx_ovf_clear got=%h exp=00000001", d); end
        do_store(B + 32'h08, 32'h55, 4'b0001);
        uart_tx_ready = 1'b1;
        do_store(B + 32'h08, 32'h66, 4'b0001);
        uart_tx_ready = 1'b0;
        total++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h66) begin bad++;
            $display("FAIL tx_push_on_pop got valid=%b data=%h exp 1/66", uart_tx_valid, uart_tx_data); end
        do_load(B, d, v);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL tx_push_on_pop_status got=%h exp=00000000", d); end
        uart_tx_ready = 1'b1;
        @(posedge clk); #1;
        uart_tx_ready = 1'b0;
        do_store(B + 32'h08, 32'h77, 4'b0010);
        total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL tx_be0_ignored got valid=%b exp=0", uart_tx_valid); end
    endtask

    task automatic test_tx_fifo();
        logic [31:0] d; logic v;
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_store(B + 32'h08, {24'h0, exp_q[i]}, 4'b0001);
        do_load(B, d, v);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL fifo_full_status got=%h exp=00000000", d); end
        do_store(B + 32'h08, 32'h55, 4'b0001);
        do_load(B, d, v);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL fifo_overflow got=%h exp=00000004", d); end
        do_store(B, 32'h0, 4'hF);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== exp_q[i]) begin bad++;
                $display("FAIL fifo_drain_%0d got valid=%b data=%h exp 1/%h", i, uart_tx_valid, uart_tx_data, exp_q[i]); end
            @(posedge clk); #1;
        end
        uart_tx_ready = 1'b0;
        total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL fifo_empty got valid=%b exp=0", uart_tx_valid); end
        do_load(B, d, v);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL fifo_status_after got=%h exp=00000001", d); end
    endtask

    task automatic test_rx();
        logic [31:0] d; logic v;
        uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
        total++; if (uart_rx_ready !== 1'b0) begin bad++; $display("FAIL rx_ready_low got=%b exp=0", uart_rx_ready); end
        do_load(B, d, v);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL rx_status got=%h exp=00000003", d); end
        uart_rx_data = 8'h77; uart_rx_valid = 1'b1;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
        do_load(B + 32'h04, d, v);
        total++; if (v !== 1'b1 || d !== 32'h5A) begin bad++; $display("FAIL rx_read got v=%b d=%h exp v=1 d=0000005a", v, d); end
        total++; if (uart_rx_ready !== 1'b1) begin bad++; $display("FAIL rx_pop_ready got=%b exp=1", uart_rx_ready); end
        do_load(B, d, v);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL rx_status_after got=%h exp=00000001", d); end
        do_load(B + 32'h04, d, v);
        total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL rx_empty_read got v=%b d=%h exp v=1 d=0", v, d); end
    endtask

    task automatic test_counters();
        logic [31:0] d; logic v;
        inst_retire = 1'b1;
        repeat (7) @(posedge clk);
        #1 inst_retire = 1'b0;
        do_load(B + 32'h14, d, v);
        total++; if (d !== 32'd7) begin bad++; $display("FAIL inst_count got=%0d exp=7", d); end
        inst_retire = 1'b1;
        do_store(B + 32'h18, 32'hDEAD_BEEF, 4'hF);
        inst_retire = 1'b0;
        do_load(B + 32'h10, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL cyc_after_clear got=%0d exp=0", d); end
        do_load(B + 32'h14, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL inst_after_clear got=%0d exp=0", d); end
        do_load(B + 32'h10, d, v);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL cyc_resume got=%0d exp=2", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic v;
        inst_retire = 1'b1;
        repeat (3) @(posedge clk);
        #1 inst_retire = 1'b0;
        do_store(32'h0000_1018, 32'h0, 4'hF);
        do_store(32'h8000_0118, 32'h0, 4'hF);
        do_load(B + 32'h14, d, v);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL unmapped_store_crst got=%0d exp=3", d); end
        do_load(B + 32'h20, d, v);
        total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL unmapped_off got v=%b d=%h exp v=1 d=0", v, d); end
        do_load(32'h0000_1000, d, v);
        total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL outside_window got v=%b d=%h exp v=1 d=0", v, d); end
        do_load(32'h0000_1010, d, v);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL outside_alias got=%h exp=0", d); end
        do_load(B + 32'h08, d, v);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL tx_reg_read got=%h exp=0", d); end
        do_store(32'h0000_1008, 32'h99, 4'hF);
        total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL outside_tx_store got valid=%b exp=0", uart_tx_valid); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d; logic v;
        uart_tx_ready = 1'b0;
        do_store(B + 32'h08, 32'hA5, 4'b0001);
        uart_rx_data = 8'h3C; uart_rx_valid = 1'b1;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h0 || uart_rx_ready !== 1'b1) begin bad++;
            $display("FAIL async_reset got txv=%b txd=%h rxr=%b exp 0/00/1", uart_tx_valid, uart_tx_data, uart_rx_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_load(B + 32'h04, d, v);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_rx_discard got=%h exp=0", d); end
        do_load(B, d, v);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL reset_status got=%h exp=00000001", d); end
    endtask

    initial begin
        test_reset();
`ifdef MMIO_TX_FIFO_EN
        test_tx_fifo();
`else
        test_tx_single();
`endif
        test_rx();
        test_counters();
        test_unmapped();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-side responder for the CPU data bus in the MMIO window at 0x8000_0000.
- Services the CPU's loads and stores that target the UART and the performance counters.
- Sits between the Riscv151 load/store path and the UART TX/RX blocks; other data addresses are handled by the memories.
- Single cycle per request; never stalls the CPU.

Parameters:
- ADDR_BASE, 32'h8000_0000, base of the MMIO window.
- COUNTER_WIDTH, 32, width of the cycle and instruction counters.
- TX_FIFO_DEPTH, 4, TX buffer depth; used only with MMIO_TX_FIFO_EN; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU data request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- req_be  in  4  store byte enables
- resp_valid  out  1  load data valid
- resp_rdata  out  32  load data
- inst_retire  in  1  one instruction retired this cycle
- uart_tx_data  out  8  byte to UART transmitter
- uart_tx_valid  out  1  TX byte available
- uart_tx_ready  in  1  transmitter accepts byte
- uart_rx_data  in  8  byte from UART receiver
- uart_rx_valid  in  1  RX byte available
- uart_rx_ready  out  1  responder can accept an RX byte

Behaviour:
- Register map (offsets from ADDR_BASE):
  - 0x00 status (R): bit0 tx_ready (TX buffer not full); bit1 rx_valid; bit2 tx_overflow (sticky); other bits 0.
  - 0x04 rx_data (R): {24'b0, byte}; pops RX.
  - 0x08 tx_data (W): pushes wdata[7:0].
  - 0x10 cycle_count (R).
  - 0x14 inst_count (R).
  - 0x18 counter_reset (W): any data.
  - Writing status clears tx_overflow.
- Handshakes:
  - Requests are always accepted when req_valid is high.
  - A load gives resp_valid=1 exactly one cycle later, with resp_rdata registered; otherwise resp_valid=0 and resp_rdata holds its last value.
  - Store data is applied at the clock edge of acceptance.
  - The `resp_rdata` for a status read reflects state before that cycle's edge.
- Unmapped offsets and addresses outside the window:
  - Loads return 0 with resp_valid=1.
  - Stores are ignored.
- TX path:
  - Single holding register.
  - A tx_data store with req_be[0]=1 while empty loads the byte and sets uart_tx_valid the next cycle.
  - The register is freed on the uart_tx_valid && uart_tx_ready edge.
  - A store while full is dropped and sets tx_overflow.
  - A store in the same cycle as a handshake that frees the register is accepted; no overflow.
  - A store with req_be[0]=0 is ignored.
- RX path:
  - One-byte holding register; uart_rx_ready = !rx_full.
  - On uart_rx_valid && uart_rx_ready the byte is captured and rx_full set.
  - Reading rx_data returns the byte and clears rx_full next cycle.
  - Reading rx_data while empty returns 0, does not pop, and has no side effect.
- Counters:
  - cycle_count increments every cycle.
  - inst_count increments when inst_retire=1.
  - Both wrap modulo 2^COUNTER_WIDTH.
  - A counter_reset store sets both to 0 at that edge; the clear wins over a same-cycle increment.
  - Reads are zero-extended to 32 bits.
- Reset (rst_n low, asynchronous): all of the following go to 0.
  - Outputs: resp_valid, resp_rdata, uart_tx_valid, uart_tx_data.
  - Internal state: counters, TX/RX holding registers, tx_overflow.
  - uart_rx_ready goes to 1.
  - Reset mid-handshake discards any pending TX/RX byte.

Optional Feature:
- MMIO_TX_FIFO_EN defined:
  - TX holding register replaced by a TX_FIFO_DEPTH-entry FIFO.
  - status bit0 = FIFO not full.
  - Overflow only when a push is attempted with the FIFO full and no same-cycle pop.
  - uart_tx_valid = FIFO not empty; uart_tx_data = FIFO head.
  - Bytes leave in order.
- MMIO_TX_FIFO_EN undefined: single holding register as above, depth effectively 1.

Decomposition:
- Shared package mmio_pkg holds:
  - offset localparams: OFF_STATUS, OFF_RX, OFF_TX, OFF_CYC, OFF_INST, OFF_CRST;
  - status bit index constants.
- One natural sub-module: mmio_fifo, a parameterised sync FIFO with push/pop/full/empty.
  - Used for the TX buffer under MMIO_TX_FIFO_EN.
  - Instantiated with depth 1 semantics otherwise, or replaced by the holding register.

Test Plan:
- Reset, then 10 idle cycles, then load 0x8000_0010 → resp_valid one cycle later with rdata=10 ±1 per the chosen sampling edge; load 0x8000_0000 → rdata=0x1.
- Store 0x41 to 0x8000_0008, hold uart_tx_ready=0 → uart_tx_valid=1, uart_tx_data=0x41; second store 0x42 → dropped, status=0x4. Raise ready → valid drops after one handshake.
- Drive uart_rx_valid with 0x5A → uart_rx_ready falls, status=0x3; load 0x8000_0004 → rdata=0x5A, then status bit1=0; a second load → rdata=0.
- Pulse inst_retire 7 times, store to 0x8000_0018 while inst_retire=1 → inst_count=0 and cycle_count=0 on the next read.
- Load 0x8000_0020 and 0x0000_1000 → rdata=0, resp_valid=1; store there → no state change.
- MMIO_TX_FIFO_EN, ready=0: store 0x11,0x22,0x33,0x44 → status bit0=0; a fifth store sets overflow. Release ready → bytes drain in order 0x11..0x44.
